// File: rtl/board_rle_encoder.sv
// Run-length encoder streaming a Life board as {pixel, run-1} bytes.
// Optional LIFE_RLE_POPCOUNT_EN adds a live-pixel counter port.
module board_rle_encoder #(
  parameter int TOTAL_PIXELS = 2073600
) (
  input  logic       HDMI_CLK,
  input  logic       RESET_N,
  input  logic       start,
  input  logic       pix_in,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
`ifdef LIFE_RLE_POPCOUNT_EN
  ,
  output logic [21:0] live_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [21:0] LAST = 22'(TOTAL_PIXELS - 1);

  state_t      state;
  logic [21:0] cnt;
  logic [7:0]  run;
  logic        cur;

  logic       out_free;
  logic       accept;
  logic       run_open;
  logic       extend;
  logic       emit;
  logic       flush_load;
  logic       load;
  logic [7:0] load_byte;
  logic       start_ok;

  assign out_free   = !out_valid || out_ready;
  assign pix_ready  = (state == RUN) && out_free;
  assign accept     = pix_valid && pix_ready;
  assign run_open   = run != 8'd0;
  assign extend     = (pix_in == cur) && (run < 8'd128);
  assign emit       = accept && run_open && !extend;
  assign flush_load = (state == FLUSH) && out_free;
  assign load       = emit || flush_load;
  assign load_byte  = {cur, 7'(run - 8'd1)};
  assign start_ok   = start && ((state == IDLE) || (state == DONE));
  assign busy       = (state == RUN) || (state == FLUSH);

  always_ff @(posedge HDMI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      cnt       <= '0;
      run       <= '0;
      cur       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      // A fresh byte overwrites a byte consumed this cycle with no bubble
      if (load) begin
        out_data  <= load_byte;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      unique case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            cnt   <= '0;
            run   <= '0;
            done  <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          if (accept) begin
            cur <= pix_in;
            run <= (run_open && extend) ? run + 8'd1 : 8'd1;
            if (cnt == LAST) begin
              state <= FLUSH;
            end else begin
              cnt <= cnt + 22'd1;
            end
          end
        end
        FLUSH: begin
          if (out_free) begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LIFE_RLE_POPCOUNT_EN
  always_ff @(posedge HDMI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      live_count <= '0;
    end else if (start_ok) begin
      live_count <= '0;
    end else if (accept && pix_in) begin
      live_count <= live_count + 22'd1;
    end
  end
`endif

endmodule
